// File: rtl/comparator_serial_nbit_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encodings,
// slice-count helper and the registered result flag bundle.
package comparator_serial_nbit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int ceil_div(input int n, input int k);
    return (n + k - 1) / k;
  endfunction

  typedef struct packed {
    logic smaller;
    logic equal;
    logic greater;
  } cmp_flags_t;

endpackage

// File: rtl/comparator_serial_nbit_if.sv
// Request/result bundle for comparator_serial_nbit, including FSM state for observation.
interface comparator_serial_nbit_if #(parameter int N = 12);

  // start is a request that is taken only while busy=0 (IDLE or DONE); a, b and
  // signed_mode are sampled on that same edge. done pulses for one cycle and the
  // smaller/equal/greater flags stay valid from then until the next done or reset.
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic         smaller;
  logic         equal;
  logic         greater;
  logic [1:0]   state;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, smaller, equal, greater, state
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, smaller, equal, greater, state
  );

endinterface

// File: rtl/comparator_nbit.sv
// Combinational N-bit unsigned magnitude comparator, reused as the per-slice compare.
module comparator_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);

    assign smaller = (a < b);
    assign equal   = (a == b);
    assign greater = (a > b);

endmodule

// File: rtl/comparator_serial_nbit.sv
// Multi-cycle MSB-first magnitude comparator: K bits per clock, optional signed
// mode (offset binary) and optional early exit on the first differing slice.
module comparator_serial_nbit
  import comparator_serial_nbit_pkg::*;
#(
    parameter int N          = 12,
    parameter int K          = 4,
    parameter bit SIGNED_EN  = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    comparator_serial_nbit_if.slave bus
);

    localparam int S  = ceil_div(N, K);
    localparam int W  = S * K;
    localparam int CW = $clog2(S + 1);

    logic [1:0]    state;
    logic [W-1:0]  sh_a, sh_b;
    logic [CW-1:0] cnt;
    logic          decided, r_lt, r_gt;
    cmp_flags_t    res;

    logic [N-1:0]  a_in, b_in;
    logic          sl_lt, sl_eq, sl_gt;
    logic          last, fin, nx_lt, nx_gt;

    // Flipping both sign bits maps two's complement onto an order-preserving unsigned range.
    always_comb begin
        a_in = bus.a;
        b_in = bus.b;
        if (SIGNED_EN && bus.signed_mode) begin
            a_in[N-1] = ~bus.a[N-1];
            b_in[N-1] = ~bus.b[N-1];
        end
    end

    comparator_nbit #(.N(K)) u_slice (
        .a       (sh_a[W-1 -: K]),
        .b       (sh_b[W-1 -: K]),
        .smaller (sl_lt),
        .equal   (sl_eq),
        .greater (sl_gt)
    );

    assign last  = (cnt == CW'(S - 1));
    assign fin   = last || (EARLY_EXIT && !sl_eq);
    assign nx_lt = decided ? r_lt : (!sl_eq && sl_lt);
    assign nx_gt = decided ? r_gt : (!sl_eq && sl_gt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            res     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    sh_a <= sh_a << K;
                    sh_b <= sh_b << K;
                    cnt  <= cnt + 1'b1;
                    if (!decided && !sl_eq) begin
                        decided <= 1'b1;
                        r_lt    <= sl_lt;
                        r_gt    <= sl_gt;
                    end
                    if (fin) begin
                        state       <= ST_DONE;
                        res.smaller <= nx_lt;
                        res.greater <= nx_gt;
                        res.equal   <= !(nx_lt || nx_gt);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; padding zeros sit below the operands.
                    if (bus.start) begin
                        sh_a    <= W'(a_in) << (W - N);
                        sh_b    <= W'(b_in) << (W - N);
                        cnt     <= '0;
                        decided <= 1'b0;
                        r_lt    <= 1'b0;
                        r_gt    <= 1'b0;
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);
    assign bus.smaller = res.smaller;
    assign bus.equal   = res.equal;
    assign bus.greater = res.greater;
    assign bus.state   = state;

endmodule
